// File: rtl/barrel_shift_pkg.sv
// rtl/barrel_shift_pkg.sv - shared types for the pipelined barrel shifter
package barrel_shift_pkg;

  // Payload fields are sized for the widest configuration the shifter
  // supports; an instance uses only the low W data bits and low SW shamt bits.
  localparam int MAX_W  = 64;
  localparam int MAX_SW = 6;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  typedef struct packed {
    logic [MAX_W-1:0]  data;
    logic [MAX_SW-1:0] shamt;
    shift_dir_e        dir;
    logic              arith;
  } stage_pay_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operand/result handshake bundle
interface pipelined_barrel_shifter_if #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
);
  logic          arg_vld;
  logic          arg_rdy;
  logic [W-1:0]  a;
  logic [SW-1:0] shamt;
  logic          dir;
  logic          arith;
  logic          res_vld;
  logic          res_rdy;
  logic [W-1:0]  res;

  modport master (
    output arg_vld, a, shamt, dir, arith, res_rdy,
    input  arg_rdy, res_vld, res
  );

  modport slave (
    input  arg_vld, a, shamt, dir, arith, res_rdy,
    output arg_rdy, res_vld, res
  );
endinterface

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one register stage shifting by 2^K
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld_i,
  output logic       in_rdy_o,
  input  stage_pay_t in_pay_i,
  output logic       out_vld_o,
  input  logic       out_rdy_i,
  output stage_pay_t out_pay_o
);
  localparam int DIST = 1 << K;

  logic         vld_q;
  stage_pay_t   pay_q;
  stage_pay_t   pay_d;
  logic [W-1:0] cur;
  logic         fill;

  // Shift by 2^K when shamt bit K is set; arithmetic right shifts refill from
  // the MSB, which every earlier arithmetic stage has kept equal to a[W-1].
  always_comb begin
    pay_d = in_pay_i;
    cur   = in_pay_i.data[W-1:0];
    fill  = (in_pay_i.dir == SHIFT_RIGHT) && in_pay_i.arith && cur[W-1];
    if (in_pay_i.shamt[K]) begin
      if (in_pay_i.dir == SHIFT_LEFT) begin
        pay_d.data[W-1:0] = cur << DIST;
      end else begin
        pay_d.data[W-1:0] = (cur >> DIST) | (fill ? ~({W{1'b1}} >> DIST) : '0);
      end
    end
  end

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_pay_o = pay_q;

  // Load whenever ready: a new item, or a bubble when the item leaves alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else if (in_rdy_o) begin
      vld_q <= in_vld_i;
      if (in_vld_i) begin
        pay_q <= pay_d;
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - SW-stage elastic barrel shifter top
module pipelined_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave sh_if
);
  logic [SW-1:0] stage_vld;
  logic [SW-1:0] in_rdy;
  logic [SW-1:0] out_rdy;
  stage_pay_t    pay_in;
  stage_pay_t    pay_out [SW];
  logic          unused_ok;

  assign pay_in = '{
    data:  MAX_W'(sh_if.a),
    shamt: MAX_SW'(sh_if.shamt),
    dir:   shift_dir_e'(sh_if.dir),
    arith: sh_if.arith
  };

  for (genvar k = 0; k < SW; k++) begin : g_stage
    stage_pay_t in_pay;
    logic       in_vld;

    if (k == 0) begin : g_first
      assign in_pay = pay_in;
      assign in_vld = sh_if.arg_vld;
    end else begin : g_next
      assign in_pay = pay_out[k-1];
      assign in_vld = stage_vld[k-1];
    end

    // Downstream readiness in closed form: some later stage holds a bubble,
    // or the consumer takes the result this cycle.
    if (k == SW-1) begin : g_tail
      assign out_rdy[k] = sh_if.res_rdy;
    end else begin : g_body
      assign out_rdy[k] = sh_if.res_rdy | ~(&stage_vld[SW-1:k+1]);
    end

    barrel_shift_stage #(
      .W(W),
      .K(k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_vld_i (in_vld),
      .in_rdy_o (in_rdy[k]),
      .in_pay_i (in_pay),
      .out_vld_o(stage_vld[k]),
      .out_rdy_i(out_rdy[k]),
      .out_pay_o(pay_out[k])
    );
  end

  assign sh_if.arg_rdy = in_rdy[0];
  assign sh_if.res_vld = stage_vld[SW-1];
  assign sh_if.res     = pay_out[SW-1].data[W-1:0];

  // Upper payload bits of the last stage and the inner stages' own ready
  // outputs (already reproduced by out_rdy) have no consumer.
  assign unused_ok = ^{pay_out[SW-1], in_rdy};

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width in bits (power of 2, at least 2).
REQ-002 SHALL have parameter SW, default $clog2(W), meaning shift-amount width and number of pipeline stages.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port arg_vld  input  1  upstream holds a valid operand set.
REQ-006 SHALL have port arg_rdy  output  1  block accepts the operand set this cycle.
REQ-007 SHALL have port a  input  W  unsigned operand.
REQ-008 SHALL have port shamt  input  SW  shift distance, 0..W-1.
REQ-009 SHALL have port dir  input  1  direction: 0 means left, 1 means right.
REQ-010 SHALL have port arith  input  1  fill with a[W-1] on right shift; ignored when dir=0.
REQ-011 SHALL have port res_vld  output  1  res holds a valid result.
REQ-012 SHALL have port res_rdy  input  1  downstream takes res this cycle.
REQ-013 SHALL have port res  output  W  shifted result.

Function
REQ-014 SHALL treat a transfer as occurring only when vld and rdy are both high on the same edge, on either side.
REQ-015 SHALL contain SW register stages; stage k (k=0..SW-1) applies a shift of 2^k when shamt bit k is set, otherwise passes data unchanged.
REQ-016 SHALL register per stage: valid, data, shamt, dir and arith; res and res_vld SHALL come directly from stage SW-1.
REQ-017 SHALL zero-fill left shifts and logical right shifts; arithmetic right shifts SHALL fill with the original a[W-1], carried through every stage.
REQ-018 SHALL produce, for an accepted input, res equal to (a << shamt) for dir=0, (a >> shamt) for dir=1/arith=0, and (signed a >>> shamt) for dir=1/arith=1.
REQ-019 SHALL present the result SW cycles after acceptance when never stalled (latency 3 for W=8).
REQ-020 SHALL compute stage readiness as rdy_k = !vld_k || rdy_(k+1), with rdy_SW = res_rdy and arg_rdy = rdy_0 (bubble-collapsing pipeline).
REQ-021 SHALL sustain one result per cycle when arg_vld and res_rdy are held high.
REQ-022 SHALL hold res and res_vld stable while res_vld=1 and res_rdy=0; no result is dropped or duplicated.
REQ-023 SHALL let a stage load a new item and hand its current item downstream on the same edge; a stage whose item leaves and gets no new item SHALL clear its valid bit.
REQ-024 SHALL pass a through unchanged when shamt=0, for any dir or arith setting.
REQ-025 SHALL deliver results in acceptance order.

Reset
REQ-026 SHALL, while rst=1, clear every stage valid bit and every data register to 0, so that res_vld=0 and res=0 on the first cycle after reset.
REQ-027 SHALL drive arg_rdy=1 in the first cycle after rst deasserts.
REQ-028 SHALL discard all in-flight items when rst asserts mid-operation; no discarded item appears at res afterwards.

Structure
REQ-029 SHALL place the direction typedef (enum SHIFT_LEFT=0, SHIFT_RIGHT=1) and the per-stage payload struct (data, shamt, dir, arith) in the shared package barrel_shift_pkg.
REQ-030 SHALL implement each stage as the sub-module barrel_shift_stage, with parameter K for the stage index and a vld/rdy handshake on both sides, instantiated SW times by a generate loop.

Verification (W=8)
REQ-031 SHALL cover: a=8'b1011_0101, shamt=3, res_rdy=1 -> dir=0 gives 8'b1010_1000; dir=1/arith=0 gives 8'b0001_0110; dir=1/arith=1 gives 8'b1111_0110; each appears exactly 3 cycles after acceptance.
REQ-032 SHALL cover: shamt=0, a=8'hC3, all four dir/arith combinations -> res=8'hC3 every time; shamt=7, a=8'h81, dir=1/arith=1 -> 8'hFF.
REQ-033 SHALL cover: 16 back-to-back random inputs, arg_vld=1, res_rdy=1 -> 16 consecutive res_vld cycles starting at cycle 3, matching a reference model in order.
REQ-034 SHALL cover: res_rdy=0 for 6 cycles with arg_vld=1 -> 3 items accepted, then arg_rdy=0 and res held stable; after res_rdy=1 all 3 results drain in order with no loss.
REQ-035 SHALL cover: rst pulsed for 1 cycle with 2 items in flight -> res_vld=0 the next cycle, neither item ever emitted, and arg_rdy=1.
